dsp7_scan_ctrl: RTL and testbench

DSP7_SCAN_CTRL -- requirements
Module: dsp7_scan_ctrl

---
 rtl/dsp7_scan_ctrl_if.sv | 20 ++
 rtl/dsp7_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_dsp7_scan_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/dsp7_scan_ctrl_if.sv
// Display-scan request/response bundle between a value source and dsp7_scan_ctrl.
interface dsp7_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        load_ack;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame;

  modport master (
    output en, load, value,
    input  load_ack, digit, an, frame
  );

  modport slave (
    input  en, load, value,
    output load_ack, digit, an, frame
  );
endinterface

// File: rtl/dsp7_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with frame-aligned value update.
// Optional leading-zero blanking is compiled in with `define DSP7_SCAN_LZB_EN.
module dsp7_scan_ctrl #(
  parameter int unsigned DIV       = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic             clk,
  input  logic             rst_n,
  dsp7_scan_ctrl_if.slave  bus
);

  localparam int unsigned CW = $clog2(DIV);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic [15:0]   pending, pending_nxt;
  logic          pend, pend_nxt;
  logic          swp, swp_nxt;

  logic          cnt_wrap_c;
  logic          frame_wrap_c;
  logic          frame_start_c;

  logic [3:0]    an_nxt, digit_nxt;
  logic          frame_nxt, ack_nxt;
  logic [3:0]    an_r, digit_r;
  logic          frame_r, ack_r;

  // State register plus registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_BLANK;
      cnt     <= '0;
      idx     <= 2'd0;
      shadow  <= 16'h0000;
      pending <= 16'h0000;
      pend    <= 1'b0;
      swp     <= 1'b0;
      an_r    <= 4'b1111;
      digit_r <= 4'h0;
      frame_r <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shadow  <= shadow_nxt;
      pending <= pending_nxt;
      pend    <= pend_nxt;
      swp     <= swp_nxt;
      an_r    <= an_nxt;
      digit_r <= digit_nxt;
      frame_r <= frame_nxt;
      ack_r   <= ack_nxt;
    end
  end

  assign cnt_wrap_c    = (cnt == CW'(DIV - 1));
  assign frame_wrap_c  = cnt_wrap_c && (idx == 2'd3);
  assign frame_start_c = (cnt == '0) && (idx == 2'd0);

  // Next-state: slot counter, digit index, BLANK/SHOW phase, value staging.
  // swp remembers that the shadow was swapped so the ack lines up with frame.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    pend_nxt    = pend;
    swp_nxt     = swp;

    if (bus.load) begin
      pending_nxt = bus.value;
      pend_nxt    = 1'b1;
    end

    if (bus.en) begin
      cnt_nxt = cnt_wrap_c ? '0 : cnt + CW'(1);
      if (cnt_wrap_c) begin
        idx_nxt = idx + 2'd1;
      end

      case (state)
        ST_BLANK: if (cnt_nxt == CW'(BLANK_CYC)) state_nxt = ST_SHOW;
        ST_SHOW:  if (cnt_wrap_c)                state_nxt = ST_BLANK;
        default:  state_nxt = ST_BLANK;
      endcase

      if (frame_start_c) begin
        swp_nxt = 1'b0;
      end

      // Shadow only moves at the frame boundary; a same-cycle load wins.
      if (frame_wrap_c) begin
        if (bus.load) begin
          shadow_nxt = bus.value;
          pend_nxt   = 1'b0;
          swp_nxt    = 1'b1;
        end else if (pend) begin
          shadow_nxt = pending;
          pend_nxt   = 1'b0;
          swp_nxt    = 1'b1;
        end
      end
    end
  end

  // Output decode from the current (pre-advance) state.
`ifdef DSP7_SCAN_LZB_EN
  logic [3:0] lit_c;
  assign lit_c = {|shadow[15:12], |shadow[15:8], |shadow[15:4], 1'b1};
`endif

  always_comb begin
    an_nxt    = 4'b1111;
    digit_nxt = shadow[{idx, 2'b00} +: 4];
    frame_nxt = 1'b0;
    ack_nxt   = 1'b0;

    if (bus.en) begin
      if (state == ST_SHOW) begin
`ifdef DSP7_SCAN_LZB_EN
        an_nxt = ~(4'b0001 << idx) | ~lit_c;
`else
        an_nxt = ~(4'b0001 << idx);
`endif
      end
      frame_nxt = frame_start_c;
      ack_nxt   = frame_start_c && swp;
    end
  end

  assign bus.an       = an_r;
  assign bus.digit    = digit_r;
  assign bus.frame    = frame_r;
  assign bus.load_ack = ack_r;

endmodule

// File: tb/tb_dsp7_scan_ctrl.sv
// Directed bench for dsp7_scan_ctrl at DIV=8, BLANK_CYC=2 (32-clock frame).
module tb_dsp7_scan_ctrl;

  localparam int unsigned DIV       = 8;
  localparam int unsigned BLANK_CYC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dsp7_scan_ctrl_if bus();

  dsp7_scan_ctrl #(.DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Expected anode pattern at frame position p (all digits lit).
  function automatic logic [3:0] m_an(int p);
    int s = (p / 8) % 4;
    int c = p % 8;
    logic [3:0] one = 4'b0001;
    if (c < int'(BLANK_CYC)) return 4'b1111;
    return ~(one << s);
  endfunction

  function automatic logic [3:0] m_dig(logic [15:0] sh, int p);
    int s = (p / 8) % 4;
    return sh[s*4 +: 4];
  endfunction

  task automatic test_reset();
    bus.en = 1'b1; bus.load = 1'b1; bus.value = 16'hFFFF; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks += 4;
    if (bus.an !== 4'b1111) begin failures++; $display("FAIL reset_an got %b exp 1111", bus.an); end
    if (bus.digit !== 4'h0) begin failures++; $display("FAIL reset_digit got %h exp 0", bus.digit); end
    if (bus.frame !== 1'b0) begin failures++; $display("FAIL reset_frame got %b exp 0", bus.frame); end
    if (bus.load_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b exp 0", bus.load_ack); end
    bus.load = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_scan();
    for (int p = 0; p < 32; p++) begin
      @(negedge clk);
      checks += 4;
      if (bus.an !== m_an(p)) begin failures++; $display("FAIL scan_an p=%0d got %b exp %b", p, bus.an, m_an(p)); end
      if (bus.digit !== 4'h0) begin failures++; $display("FAIL scan_digit p=%0d got %h exp 0", p, bus.digit); end
      if (bus.frame !== (p == 0)) begin failures++; $display("FAIL scan_frame p=%0d got %b exp %b", p, bus.frame, p == 0); end
      if (bus.load_ack !== 1'b0) begin failures++; $display("FAIL scan_ack p=%0d got %b exp 0", p, bus.load_ack); end
    end
  endtask

  task automatic test_load();
    logic [15:0] sh;
    for (int p = 0; p < 64; p++) begin
      @(negedge clk);
      sh = (p < 32) ? 16'h0000 : 16'h1234;
      checks += 4;
      if (bus.an !== m_an(p)) begin failures++; $display("FAIL load_an p=%0d got %b exp %b", p, bus.an, m_an(p)); end
      if (bus.digit !== m_dig(sh, p)) begin failures++; $display("FAIL load_digit p=%0d got %h exp %h", p, bus.digit, m_dig(sh, p)); end
      if (bus.frame !== (p % 32 == 0)) begin failures++; $display("FAIL load_frame p=%0d got %b exp %b", p, bus.frame, p % 32 == 0); end
      if (bus.load_ack !== (p == 32)) begin failures++; $display("FAIL load_ack p=%0d got %b exp %b", p, bus.load_ack, p == 32); end
      bus.load  = (p + 1 == 11);
      bus.value = 16'h1234;
    end
  endtask

  task automatic test_last_wins();
    logic [15:0] sh;
    for (int p = 0; p < 64; p++) begin
      @(negedge clk);
      sh = (p < 32) ? 16'h1234 : 16'h2222;
      checks += 3;
      if (bus.an !== m_an(p)) begin failures++; $display("FAIL lastwins_an p=%0d got %b exp %b", p, bus.an, m_an(p)); end
      if (bus.digit !== m_dig(sh, p)) begin failures++; $display("FAIL lastwins_digit p=%0d got %h exp %h", p, bus.digit, m_dig(sh, p)); end
      if (bus.load_ack !== (p == 32)) begin failures++; $display("FAIL lastwins_ack p=%0d got %b exp %b", p, bus.load_ack, p == 32); end
      bus.load  = (p + 1 == 5) || (p + 1 == 20);
      bus.value = (p + 1 == 5) ? 16'h1111 : 16'h2222;
    end
  endtask

  task automatic test_wrap_load();
    logic [15:0] sh;
    for (int p = 0; p < 64; p++) begin
      @(negedge clk);
      sh = (p < 32) ? 16'h2222 : 16'h5678;
      checks += 3;
      if (bus.digit !== m_dig(sh, p)) begin failures++; $display("FAIL wrapload_digit p=%0d got %h exp %h", p, bus.digit, m_dig(sh, p)); end
      if (bus.frame !== (p % 32 == 0)) begin failures++; $display("FAIL wrapload_frame p=%0d got %b exp %b", p, bus.frame, p % 32 == 0); end
      if (bus.load_ack !== (p == 32)) begin failures++; $display("FAIL wrapload_ack p=%0d got %b exp %b", p, bus.load_ack, p == 32); end
      bus.load  = (p + 1 == 31);
      bus.value = 16'h5678;
    end
  endtask

  // en low for 5 clocks in slot 2 SHOW; a non-BCD load lands while paused.
  task automatic test_enable();
    int p = 0;
    logic [15:0] sh;
    logic paused;
    for (int t = 0; t < 38; t++) begin
      @(negedge clk);
      paused = (t >= 20) && (t <= 24);
      sh = (p < 32) ? 16'h5678 : 16'h9ABC;
      checks += 4;
      if (paused) begin
        if (bus.an !== 4'b1111) begin failures++; $display("FAIL en_an_paused t=%0d got %b exp 1111", t, bus.an); end
        if (bus.digit !== m_dig(sh, p)) begin failures++; $display("FAIL en_digit_paused t=%0d got %h exp %h", t, bus.digit, m_dig(sh, p)); end
        if (bus.frame !== 1'b0) begin failures++; $display("FAIL en_frame_paused t=%0d got %b exp 0", t, bus.frame); end
        if (bus.load_ack !== 1'b0) begin failures++; $display("FAIL en_ack_paused t=%0d got %b exp 0", t, bus.load_ack); end
      end else begin
        if (bus.an !== m_an(p)) begin failures++; $display("FAIL en_an t=%0d got %b exp %b", t, bus.an, m_an(p)); end
        if (bus.digit !== m_dig(sh, p)) begin failures++; $display("FAIL en_digit t=%0d got %h exp %h", t, bus.digit, m_dig(sh, p)); end
        if (bus.frame !== (p % 32 == 0)) begin failures++; $display("FAIL en_frame t=%0d got %b exp %b", t, bus.frame, p % 32 == 0); end
        if (bus.load_ack !== (p == 32)) begin failures++; $display("FAIL en_ack t=%0d got %b exp %b", t, bus.load_ack, p == 32); end
        p++;
      end
      bus.en    = !((t + 1 >= 20) && (t + 1 <= 24));
      bus.load  = (t + 1 == 22);
      bus.value = 16'h9ABC;
    end
  endtask

  // Reset mid-frame with a pending value: nothing survives, no ack later.
  task automatic test_reset_pend();
    bus.load = 1'b1; bus.value = 16'h4321;
    @(negedge clk);
    bus.load = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks += 4;
    if (bus.an !== 4'b1111) begin failures++; $display("FAIL rstpend_an got %b exp 1111", bus.an); end
    if (bus.digit !== 4'h0) begin failures++; $display("FAIL rstpend_digit got %h exp 0", bus.digit); end
    if (bus.frame !== 1'b0) begin failures++; $display("FAIL rstpend_frame got %b exp 0", bus.frame); end
    if (bus.load_ack !== 1'b0) begin failures++; $display("FAIL rstpend_ack got %b exp 0", bus.load_ack); end
    rst_n = 1'b1;
    for (int p = 0; p < 33; p++) begin
      @(negedge clk);
      checks += 4;
      if (bus.an !== m_an(p)) begin failures++; $display("FAIL rstpend_an p=%0d got %b exp %b", p, bus.an, m_an(p)); end
      if (bus.digit !== 4'h0) begin failures++; $display("FAIL rstpend_digit p=%0d got %h exp 0", p, bus.digit); end
      if (bus.frame !== (p % 32 == 0)) begin failures++; $display("FAIL rstpend_frame p=%0d got %b exp %b", p, bus.frame, p % 32 == 0); end
      if (bus.load_ack !== 1'b0) begin failures++; $display("FAIL rstpend_ack p=%0d got %b exp 0", p, bus.load_ack); end
    end
  endtask

`ifdef DSP7_SCAN_LZB_EN
  task automatic test_lzb();
    logic [15:0] sh;
    logic [3:0]  exp_an;
    logic [3:0]  one = 4'b0001;
    int s;
    bus.load = 1'b1; bus.value = 16'h0040;
    for (int p = 33; p < 96; p++) begin
      @(negedge clk);
      bus.load = 1'b0;
      sh = (p < 64) ? 16'h0000 : 16'h0040;
      s = (p / 8) % 4;
      if ((p % 8) < int'(BLANK_CYC)) exp_an = 4'b1111;
      else if (s == 0 || (sh >> (4 * s)) != 16'h0000) exp_an = ~(one << s);
      else exp_an = 4'b1111;
      checks += 2;
      if (bus.an !== exp_an) begin failures++; $display("FAIL lzb_an p=%0d got %b exp %b", p, bus.an, exp_an); end
      if (bus.load_ack !== (p == 64)) begin failures++; $display("FAIL lzb_ack p=%0d got %b exp %b", p, bus.load_ack, p == 64); end
    end
  endtask
`endif

  initial begin
    bus.en = 1'b0; bus.load = 1'b0; bus.value = 16'h0000;
    test_reset();
    test_scan();
    test_load();
    test_last_wins();
    test_wrap_load();
    test_enable();
    test_reset_pend();
`ifdef DSP7_SCAN_LZB_EN
    test_lzb();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
